div_seq_ctrl: RTL and testbench

//  Sequencer between the execute-stage M-extension issue logic and the radix-4 long-division datapath.

---
 rtl/div_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencer between the M-extension issue logic and the radix-4 divider datapath.
// It takes one DIV/DIVU/REM/REMU request at a time and drives the datapath init/advance/last
// strobes. Divide-by-zero and signed overflow are detected at accept, and the fixed result
// replaces the datapath output. kill aborts any operation in progress.
// Optional feature: define DIV_FASTPATH_EN so that zero/overflow requests skip the datapath and
// respond one cycle after accept.
module div_seq_ctrl #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned ITER  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             kill,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [31:0]      div_dividend,
    output logic [31:0]      div_divisor,
    output logic             div_unsign,
    output logic             div_init,
    output logic             div_advance,
    output logic             div_last,
    input  logic [31:0]      div_quot,
    input  logic [31:0]      div_remd
);

    localparam int unsigned    CntW    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

    typedef enum logic [1:0] {StIdle, StIter, StLast, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        op_q;
    logic [31:0]       rs1_q, rs2_q;
    logic [TAG_W-1:0]  tag_q;
    logic              zero_q, ovf_q;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

    logic accept;
    logic req_zero;
    logic req_ovf;
    logic fast;

    // Fixed result for the special cases: zero -> quot all-ones / rem dividend, ovf -> INT_MIN / 0.
    function automatic logic [31:0] special_val(input logic is_rem, input logic is_zero,
                                                input logic [31:0] dividend);
        if (is_zero) begin
            return is_rem ? dividend : 32'hFFFF_FFFF;
        end
        return is_rem ? 32'h0000_0000 : 32'h8000_0000;
    endfunction

    assign req_ready = (state_q == StIdle) & ~kill;
    assign accept    = req_valid & req_ready;
    assign req_zero  = (req_rs2 == 32'h0000_0000);
    assign req_ovf   = ~req_op[0] & (req_rs1 == 32'h8000_0000) & (req_rs2 == 32'hFFFF_FFFF);

`ifdef DIV_FASTPATH_EN
    assign fast = accept & (req_zero | req_ovf);
`else
    assign fast = 1'b0;
`endif

    // State, counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
        end
    end

    // Request latch: operands, op, tag and special-case flags are captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            tag_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= req_op;
            rs1_q  <= req_rs1;
            rs2_q  <= req_rs2;
            tag_q  <= req_tag;
            zero_q <= req_zero;
            ovf_q  <= req_ovf;
        end
    end

    // Next-state logic; kill overrides everything and returns to idle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        if (kill) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cnt_d = '0;
                        if (fast) begin
                            state_d    = StDone;
                            rsp_data_d = special_val(req_op[1], req_zero, req_rs1);
                            rsp_tag_d  = req_tag;
                        end else begin
                            state_d = StIter;
                        end
                    end
                end
                StIter: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StLast;
                        cnt_d   = '0;
                    end
                end
                StLast: begin
                    state_d   = StDone;
                    rsp_tag_d = tag_q;
                    if (zero_q | ovf_q) begin
                        rsp_data_d = special_val(op_q[1], zero_q, rs1_q);
                    end else begin
                        rsp_data_d = op_q[1] ? div_remd : div_quot;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs: strobes are decoded from state, so at most one is high in any cycle.
    always_comb begin
        busy         = (state_q != StIdle);
        rsp_valid    = (state_q == StDone);
        div_init     = accept & ~fast;
        div_advance  = (state_q == StIter);
        div_last     = (state_q == StLast);
        div_dividend = accept ? req_rs1 : rs1_q;
        div_divisor  = accept ? req_rs2 : rs2_q;
        div_unsign   = accept ? req_op[0] : op_q[0];
    end

    assign rsp_data = rsp_data_q;
    assign rsp_tag  = rsp_tag_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl; the bench drives the datapath results itself.
module tb_div_seq_ctrl;

    localparam int unsigned TAG_W = 5;
`ifdef DIV_FASTPATH_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 18;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [31:0]      req_rs1 = '0;
    logic [31:0]      req_rs2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             kill = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic [31:0]      div_dividend;
    logic [31:0]      div_divisor;
    logic             div_unsign;
    logic             div_init;
    logic             div_advance;
    logic             div_last;
    logic [31:0]      div_quot = '0;
    logic [31:0]      div_remd = '0;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl #(.TAG_W(TAG_W), .ITER(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_tag      (req_tag),
        .kill         (kill),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .busy         (busy),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_unsign   (div_unsign),
        .div_init     (div_init),
        .div_advance  (div_advance),
        .div_last     (div_last),
        .div_quot     (div_quot),
        .div_remd     (div_remd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Issue one request, drive the datapath result, and wait for rsp_valid (bounded).
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [TAG_W-1:0] tag,
                         input logic [31:0] dq, input logic [31:0] dr,
                         input int exp_lat, input logic [31:0] exp_data);
        int n;
        int inits;
        int adv;
        int lst;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_tag   = tag;
        div_quot  = dq;
        div_remd  = dr;
        #1;
        chk({name, " req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({name, " dividend"}, div_dividend, rs1);
        chk({name, " divisor"}, div_divisor, rs2);
        chk({name, " unsign"}, {31'b0, div_unsign}, {31'b0, op[0]});
        inits = int'(div_init);
        n = 0;
        adv = 0;
        lst = 0;
        @(posedge clk);
        while (n < 40) begin
            @(negedge clk);
            if (n == 0) req_valid = 1'b0;
            n++;
            inits += int'(div_init);
            adv   += int'(div_advance);
            lst   += int'(div_last);
            if (rsp_valid) break;
        end
        chk({name, " latency"}, n, exp_lat);
        chk({name, " init count"}, inits, (exp_lat == 18) ? 1 : 0);
        chk({name, " advance count"}, adv, (exp_lat == 18) ? 16 : 0);
        chk({name, " last count"}, lst, (exp_lat == 18) ? 1 : 0);
        chk({name, " data"}, rsp_data, exp_data);
        chk({name, " tag"}, {27'b0, rsp_tag}, {27'b0, tag});
    endtask

    task automatic finish_rsp(input string name);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk({name, " rsp_valid cleared"}, {31'b0, rsp_valid}, 32'd0);
        chk({name, " busy cleared"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk("reset rsp_tag", {27'b0, rsp_tag}, 32'd0);
        chk("reset strobes", {29'b0, div_init, div_advance, div_last}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: DIV 100/7 tag 3, then hold the response for 3 cycles
        issue("div100_7", 2'b00, 32'd100, 32'd7, 5'd3, 32'd14, 32'd2, 18, 32'd14);
        repeat (3) begin
            @(negedge clk);
            chk("hold data", rsp_data, 32'd14);
            chk("hold tag", {27'b0, rsp_tag}, 32'd3);
            chk("hold req_ready", {31'b0, req_ready}, 32'd0);
            chk("hold rsp_valid", {31'b0, rsp_valid}, 32'd1);
        end
        finish_rsp("div100_7");

        // 2: signed / unsigned remainder and quotient
        issue("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
              18, 32'hFFFF_FFFF);
        finish_rsp("rem_m7_2");
        issue("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
              18, 32'hFFFF_FFFD);
        finish_rsp("div_m7_2");
        issue("remu_fff9_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h7FFF_FFFC, 32'd1, 18, 32'd1);
        finish_rsp("remu_fff9_2");

        // 3: unsigned large and signed overflow (datapath returns garbage to expose override)
        issue("divu_max_16", 2'b01, 32'hFFFF_FFFF, 32'd16, 5'd7, 32'h0FFF_FFFF, 32'd15,
              18, 32'h0FFF_FFFF);
        finish_rsp("divu_max_16");
        issue("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'hDEAD_BEEF,
              32'hCAFE_F00D, SPECIAL_LAT, 32'h8000_0000);
        finish_rsp("div_ovf");
        issue("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'hDEAD_BEEF,
              32'hCAFE_F00D, SPECIAL_LAT, 32'd0);
        finish_rsp("rem_ovf");

        // 4: divide by zero
        issue("div_5_0", 2'b00, 32'd5, 32'd0, 5'd10, 32'h1234_5678, 32'h9ABC_DEF0,
              SPECIAL_LAT, 32'hFFFF_FFFF);
        finish_rsp("div_5_0");
        issue("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd11, 32'h1234_5678, 32'h9ABC_DEF0,
              SPECIAL_LAT, 32'd5);
        finish_rsp("remu_5_0");

        // 5: kill at the 5th ITER cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_rs1   = 32'd20;
        req_rs2   = 32'd4;
        req_tag   = 5'd12;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("kill pre advance", {31'b0, div_advance}, 32'd1);
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        #1;
        chk("kill busy", {31'b0, busy}, 32'd0);
        chk("kill req_ready", {31'b0, req_ready}, 32'd1);
        chk("kill rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("kill advance", {31'b0, div_advance}, 32'd0);

        // kill with a request in idle: no accept
        @(negedge clk);
        kill      = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("idle kill req_ready", {31'b0, req_ready}, 32'd0);
        chk("idle kill init", {31'b0, div_init}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        kill      = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("idle kill busy", {31'b0, busy}, 32'd0);

        issue("div_9_3", 2'b00, 32'd9, 32'd3, 5'd13, 32'd3, 32'd0, 18, 32'd3);
        finish_rsp("div_9_3");

        // kill in DONE together with rsp_ready drops the response
        issue("div_10_5", 2'b00, 32'd10, 32'd5, 5'd14, 32'd2, 32'd0, 18, 32'd2);
        kill      = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill      = 1'b0;
        rsp_ready = 1'b0;
        #1;
        chk("done kill rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("done kill busy", {31'b0, busy}, 32'd0);

        // 6: asynchronous reset mid-ITER
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_rs1   = 32'd50;
        req_rs2   = 32'd5;
        req_tag   = 5'd15;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy", {31'b0, busy}, 32'd0);
        chk("arst advance", {31'b0, div_advance}, 32'd0);
        chk("arst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("arst rsp_data", rsp_data, 32'd0);
        chk("arst rsp_tag", {27'b0, rsp_tag}, 32'd0);
        chk("arst req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        issue("divu_50_5", 2'b01, 32'd50, 32'd5, 5'd16, 32'd10, 32'd0, 18, 32'd10);
        finish_rsp("divu_50_5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
